fetch_stage: RTL and testbench
==============================

# fetch_stage

Fetch stage and IF/ID pipeline register of the pipelined MIPS core. It holds the PC and drives the instruction-memory address. It captures each fetched instruction into the IF/ID register, whose Op/Funct fields feed the ID-stage control decoder. It consumes the decoder's NPCOp to redirect the PC for beq/j/jal/jr, honouring the hazard unit's stall.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word inserted as a bubble on flush.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall  in  1  from hazard unit; holds PC and IF/ID.
- npc_op  in  2  decoder NPCOp for the ID instruction: 0 sequential, 1 branch, 2 jump, 3 jr.
- br_equal  in  1  ID-stage rs==rt compare result; qualifies branch.
- jr_target  in  32  forwarded rs value for jr.
- imem_addr  out  32  instruction-memory address; equals PC (combinational).
- imem_rdata  in  32  instruction word at imem_addr; combinational read, same cycle.
- if_id_instr  out  32  IF/ID instruction (Op = [31:26], Funct = [5:0]).
- if_id_pc4  out  32  PC+4 of the IF/ID instruction.
- if_id_valid  out  1  IF/ID holds a real instruction; 0 for a bubble.
- redirect  out  1  combinational; PC is being redirected this cycle.

## Operation
- Redirect condition: if_id_valid=1 and stall=0, and one of the following:
  - npc_op=2 (jump)
  - npc_op=3 (jr)
  - npc_op=1 (branch) with br_equal=1
- npc_op is ignored when if_id_valid=0.
- Redirect targets:
  - Branch: if_id_pc4 + (sext(if_id_instr[15:0]) << 2).
  - Jump: {if_id_pc4[31:28], if_id_instr[25:0], 2'b00}.
  - jr: jr_target. Bits [1:0] are used as given; no alignment check.
- Next PC:
  - rst gives RESET_PC.
  - Otherwise stall gives the PC unchanged.
  - Otherwise redirect gives the redirect target.
  - Otherwise PC+4.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.
- IF/ID update, evaluated in priority order:
  - rst: instr=NOP_INSTR, pc4=0, valid=0.
  - stall: hold all fields, even when a redirect condition would otherwise apply. Stall suppresses redirect.
  - redirect (without delay slot): instr=NOP_INSTR, valid=0, pc4=PC+4. The wrong-path fetch is squashed.
  - else: instr=imem_rdata, pc4=PC+4, valid=1.
- npc_op=1 with br_equal=0 means not taken: sequential fetch, no flush.

## Timing
- Reset values: PC=RESET_PC, imem_addr=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc4=0, if_id_valid=0, redirect=0.
- Fetch latency: the instruction at PC appears on if_id_instr one cycle after PC is presented.
- Redirect penalty: the target is presented on imem_addr the cycle after the control-transfer instruction is in ID. Cost is one bubble, or zero with a delay slot.
- Stall held N cycles: PC and IF/ID are unchanged for exactly N cycles. A pending redirect resolves in the first cycle with stall=0.
- rst asserted mid-operation: overrides stall and redirect in the same edge.
- Back-to-back control transfers: a jump landing on a jump redirects again the cycle after the target enters ID.

## Configuration
- DELAY_SLOT_EN defined:
  - Architectural branch delay slot.
  - On redirect, IF/ID captures imem_rdata normally with valid=1; the slot instruction is not squashed.
  - Penalty is zero bubbles.
- DELAY_SLOT_EN undefined:
  - Flush on redirect as described in Operation; one bubble per taken transfer.

## Test plan
- Reset: assert rst 2 cycles with stall=1 -> imem_addr=32'h3000, if_id_valid=0, if_id_instr=0. First release edge latches the word at 3000, with pc4=3004.
- Sequential: imem returns 4 distinct words -> if_id_instr follows 1 cycle behind; pc4 = 3004, 3008, 300C, 3010.
- Taken beq at 3008 with imm=16'hFFFE and br_equal=1 -> next imem_addr=3004. Without the macro the next IF/ID is a bubble; with DELAY_SLOT_EN it holds the word at 300C.
- Not-taken beq (br_equal=0) -> imem_addr continues 3010, 3014, no bubble. jal with instr[25:0]=26'h0000C10 -> imem_addr=32'h0000_3040.
- Stall: stall=1 for 3 cycles while a jump is in ID -> PC and IF/ID frozen, redirect=0. The jump redirects on the first unstalled cycle.
- jr with jr_target=32'h0000_3100 while rst rises in the same cycle -> PC=RESET_PC and IF/ID cleared; no jump to 3100.

Source files
------------

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory bus between fetch and imem.
// Fetch drives the address; memory returns the word combinationally.
interface fetch_stage_if;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;

   modport master (
      output imem_addr,
      input  imem_rdata
   );

   modport slave (
      input  imem_addr,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, imem addressing and the IF/ID register.
// Macro DELAY_SLOT_EN keeps the slot instruction on a redirect.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_3000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic [1:0]  npc_op,
   input  logic        br_equal,
   input  logic [31:0] jr_target,
   fetch_stage_if.master imem,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc4,
   output logic        if_id_valid,
   output logic        redirect
);

   localparam logic [1:0] NPC_SEQ = 2'd0;
   localparam logic [1:0] NPC_BR  = 2'd1;
   localparam logic [1:0] NPC_J   = 2'd2;
   localparam logic [1:0] NPC_JR  = 2'd3;

   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] br_target;
   logic [31:0] j_target;
   logic [31:0] target;
   logic        take;

   assign imem.imem_addr = pc;
   assign pc_plus4 = pc + 32'd4;

   assign br_target = if_id_pc4
      + {{14{if_id_instr[15]}}, if_id_instr[15:0], 2'b00};

   assign j_target = {if_id_pc4[31:28], if_id_instr[25:0], 2'b00};

   // Decode the ID instruction's transfer kind and its target
   always_comb begin
      take   = 1'b0;
      target = pc_plus4;
      unique case (npc_op)
         NPC_SEQ: begin
            take   = 1'b0;
            target = pc_plus4;
         end
         NPC_BR: begin
            take   = br_equal;
            target = br_target;
         end
         NPC_J: begin
            take   = 1'b1;
            target = j_target;
         end
         NPC_JR: begin
            take   = 1'b1;
            target = jr_target;
         end
      endcase
   end

   assign redirect = if_id_valid & ~stall & take;

   // PC: reset, hold on stall, redirect, else sequential
   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (!stall) begin
         pc <= redirect ? target : pc_plus4;
      end
   end

   // IF/ID: capture the fetched word, squash it on a redirect
   always_ff @(posedge clk) begin
      if (rst) begin
         if_id_instr <= NOP_INSTR;
         if_id_pc4   <= 32'd0;
         if_id_valid <= 1'b0;
      end else if (!stall) begin
         if_id_pc4 <= pc_plus4;
`ifdef DELAY_SLOT_EN
         if_id_instr <= imem.imem_rdata;
         if_id_valid <= 1'b1;
`else
         if (redirect) begin
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
         end else begin
            if_id_instr <= imem.imem_rdata;
            if_id_valid <= 1'b1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vectors against an architectural model.
// Honours DELAY_SLOT_EN in the same way as the design.
module tb_fetch_stage;

   localparam logic [31:0] RST_PC = 32'h0000_3000;
   localparam logic [31:0] NOP    = 32'h0000_0000;
   localparam int          NV     = 29;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic [1:0]  npc_op;
   logic        br_equal;
   logic [31:0] jr_target;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic        redirect;

   int checks = 0;
   int failures = 0;

   fetch_stage_if ifc ();

   fetch_stage #(
      .RESET_PC  (RST_PC),
      .NOP_INSTR (NOP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .npc_op      (npc_op),
      .br_equal    (br_equal),
      .jr_target   (jr_target),
      .imem        (ifc.master),
      .if_id_instr (if_id_instr),
      .if_id_pc4   (if_id_pc4),
      .if_id_valid (if_id_valid),
      .redirect    (redirect)
   );

   always #5 clk = ~clk;

   // Instruction memory contents
   function automatic logic [31:0] mem(input logic [31:0] a);
      case (a)
         32'h0000_3000: return 32'h2001_0001;
         32'h0000_3004: return 32'h2002_0002;
         32'h0000_3008: return 32'h1000_FFFE;
         32'h0000_300C: return 32'h2003_0003;
         32'h0000_3010: return 32'h1000_0005;
         32'h0000_3014: return 32'h2005_0005;
         32'h0000_3018: return 32'h0C00_0C10;
         32'h0000_3040: return 32'h0800_0C14;
         32'h0000_3050: return 32'h0800_0C18;
         32'h0000_3060: return 32'h03E0_0008;
         default:       return ~a;
      endcase
   endfunction

   assign ifc.imem_rdata = mem(ifc.imem_addr);

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Architectural state of the model
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic [31:0] m_pc4;
   logic        m_valid;
   bit          m_ok = 0;

   function automatic bit m_taken();
      if (!m_valid || stall) return 0;
      if (npc_op == 2'd2 || npc_op == 2'd3) return 1;
      return npc_op == 2'd1 && br_equal;
   endfunction

   function automatic logic [31:0] m_target();
      int off;
      case (npc_op)
         2'd1: begin
            off = int'($signed(m_instr[15:0])) * 4;
            return m_pc4 + 32'(off);
         end
         2'd2: return (m_pc4 & 32'hF000_0000)
                      | (32'(m_instr[25:0]) * 32'd4);
         default: return jr_target;
      endcase
   endfunction

   // Advance the model on every clock edge
   always @(posedge clk) begin
      logic [31:0] nxt;
      if (rst) begin
         m_pc    = RST_PC;
         m_instr = NOP;
         m_pc4   = 0;
         m_valid = 0;
         m_ok    = 1;
      end else if (!stall) begin
         if (m_taken()) begin
            nxt = m_target();
`ifdef DELAY_SLOT_EN
            m_instr = mem(m_pc);
            m_valid = 1;
`else
            m_instr = NOP;
            m_valid = 0;
`endif
         end else begin
            nxt = m_pc + 4;
            m_instr = mem(m_pc);
            m_valid = 1;
         end
         m_pc4 = m_pc + 4;
         m_pc  = nxt;
      end
   end

   // Compare DUT to model mid-cycle
   always @(negedge clk) begin
      if (m_ok) begin
         chk("imem_addr", ifc.imem_addr, m_pc);
         chk("if_id_instr", if_id_instr, m_instr);
         chk("if_id_pc4", if_id_pc4, m_pc4);
         chk("if_id_valid", 32'(if_id_valid), 32'(m_valid));
         chk("redirect", 32'(redirect), 32'(m_taken()));
      end
   end

   typedef struct {
      logic        r;
      logic        s;
      logic [1:0]  op;
      logic        be;
      logic [31:0] jr;
   } vec_t;

   vec_t v [NV];

   task automatic apply(input int i);
      rst       = v[i].r;
      stall     = v[i].s;
      npc_op    = v[i].op;
      br_equal  = v[i].be;
      jr_target = v[i].jr;
   endtask

   // Hand-computed expectations at chosen vectors
   task automatic pin(input int i);
      case (i)
         1: begin
            chk("rst_addr", ifc.imem_addr, 32'h0000_3000);
            chk("rst_instr", if_id_instr, 32'h0);
            chk("rst_valid", 32'(if_id_valid), 32'h0);
            chk("rst_pc4", if_id_pc4, 32'h0);
         end
         3: begin
            chk("first_instr", if_id_instr, 32'h2001_0001);
            chk("first_pc4", if_id_pc4, 32'h0000_3004);
         end
         5: chk("beq_redirect", 32'(redirect), 32'h1);
         6: begin
            chk("beq_target", ifc.imem_addr, 32'h0000_3004);
`ifdef DELAY_SLOT_EN
            chk("slot_instr", if_id_instr, 32'h2003_0003);
`else
            chk("bubble_valid", 32'(if_id_valid), 32'h0);
`endif
         end
         8: chk("nt_beq_redirect", 32'(redirect), 32'h0);
         11: begin
            chk("nt_seq_addr", ifc.imem_addr, 32'h0000_3018);
            chk("nt_no_bubble", 32'(if_id_valid), 32'h1);
         end
         13: chk("jal_target", ifc.imem_addr, 32'h0000_3040);
         14, 15, 16: begin
            chk("stall_redirect", 32'(redirect), 32'h0);
            chk("stall_addr", ifc.imem_addr, 32'h0000_3044);
            chk("stall_pc4", if_id_pc4, 32'h0000_3044);
         end
         17: chk("unstall_redirect", 32'(redirect), 32'h1);
         18: chk("j_target", ifc.imem_addr, 32'h0000_3050);
         20: chk("b2b_target", ifc.imem_addr, 32'h0000_3060);
         22: begin
            chk("jr_rst_addr", ifc.imem_addr, 32'h0000_3000);
            chk("jr_rst_valid", 32'(if_id_valid), 32'h0);
         end
         25: chk("jr_high", ifc.imem_addr, 32'hFFFF_FFFC);
         26: begin
            chk("wrap_addr", ifc.imem_addr, 32'h0);
            chk("wrap_pc4", if_id_pc4, 32'h0);
         end
         28: begin
            chk("rst2_addr", ifc.imem_addr, 32'h0000_3000);
            chk("rst2_instr", if_id_instr, 32'h0);
         end
         default: ;
      endcase
   endtask

   initial begin
      for (int i = 0; i < NV; i++) v[i] = '{1'b0, 1'b0, 2'd0, 1'b0, 32'h0};
      v[0]  = '{1'b1, 1'b1, 2'd0, 1'b0, 32'h0};
      v[1]  = '{1'b1, 1'b1, 2'd0, 1'b0, 32'h0};
      v[5]  = '{1'b0, 1'b0, 2'd1, 1'b1, 32'h0};
      v[8]  = '{1'b0, 1'b0, 2'd1, 1'b0, 32'h0};
      v[10] = '{1'b0, 1'b0, 2'd1, 1'b0, 32'h0};
      v[12] = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h0};
      v[14] = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h0};
      v[15] = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h0};
      v[16] = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h0};
      v[17] = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h0};
      v[19] = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h0};
      v[21] = '{1'b1, 1'b0, 2'd3, 1'b0, 32'h0000_3100};
      v[24] = '{1'b0, 1'b0, 2'd3, 1'b0, 32'hFFFF_FFFC};
      v[27] = '{1'b1, 1'b1, 2'd2, 1'b0, 32'h0};

      for (int i = 0; i < NV; i++) begin
         apply(i);
         if (i > 0) begin
            @(negedge clk);
            pin(i);
         end
         @(posedge clk);
         #1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
